// File: rtl/sent_pkg.sv
// Shared constants and types for the SENT receive pulse decoder.
package sent_pkg;

    // A sync/calibration pulse is 56 ticks; a nibble of value v is 12+v ticks.
    localparam int SYNC_TICKS = 56;
    localparam int NIB_BASE   = 12;
    localparam int NIBBLES    = 8;

    // Rounded-division datapath widths.
    localparam int NUM_W = 24;
    localparam int DEN_W = 17;
    localparam int Q_W   = 7;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SYNC    = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } sent_err_t;

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        DECODE     = 2'd1,
        CHECK_SYNC = 2'd2
    } sent_state_t;

    // True when a rounded tick count maps onto a legal nibble value.
    function automatic logic q_in_range(input logic [Q_W-1:0] q);
        return (q >= Q_W'(NIB_BASE)) && (q <= Q_W'(NIB_BASE + 15));
    endfunction

    // Tick count to nibble value.
    function automatic logic [3:0] nibble_of(input logic [Q_W-1:0] q);
        logic [Q_W-1:0] w_diff;
        w_diff = q - Q_W'(NIB_BASE);
        return w_diff[3:0];
    endfunction

endpackage

// File: rtl/sent_rx_pulse_decoder_if.sv
// Output bundle of the SENT receive pulse decoder. The decoder drives the
// master side; consumers attach to the slave side. Every *_valid_o, sync_o
// and err_o is a single-cycle strobe with no back-pressure: the consumer
// must sample the qualified data in the cycle the strobe is high.
interface sent_rx_pulse_decoder_if
    import sent_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [3:0]       nibble_o;
    logic             nibble_valid_o;
    logic [2:0]       nibble_idx_o;
    logic             sync_o;
    logic [CNT_W-1:0] tick_cycles_o;
    logic [3:0]       status_o;
    logic [23:0]      data_o;
    logic [3:0]       crc_o;
    logic             frame_valid_o;
    logic             err_o;
    logic [1:0]       err_code_o;
    sent_state_t      state_o;

    modport master (
        output nibble_o, nibble_valid_o, nibble_idx_o, sync_o, tick_cycles_o,
               status_o, data_o, crc_o, frame_valid_o, err_o, err_code_o,
               state_o
    );

    modport slave (
        input nibble_o, nibble_valid_o, nibble_idx_o, sync_o, tick_cycles_o,
              status_o, data_o, crc_o, frame_valid_o, err_o, err_code_o,
              state_o
    );
endinterface

// File: rtl/sent_rx_divider.sv
// Restoring divider producing a 7-bit quotient: one load cycle, then one
// quotient bit per cycle MSB first. The caller guarantees num < 128*den.
module sent_rx_divider
    import sent_pkg::*;
(
    input  logic             clk_rx,
    input  logic             reset_n_rx,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_q
);

    logic [NUM_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [Q_W-1:0]   r_q;
    logic [2:0]       r_bit;
    logic             r_busy;
    logic             r_done;

    logic [NUM_W-1:0] w_trial;
    logic             w_fits;

    // Divisor aligned to the quotient bit currently being resolved.
    always_comb begin
        w_trial = {{(NUM_W-DEN_W){1'b0}}, r_den} << r_bit;
        w_fits  = (r_rem >= w_trial);
    end

    // Load on start, then subtract-and-shift for Q_W iterations.
    always_ff @(posedge clk_rx) begin
        if (!reset_n_rx) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_q    <= '0;
            r_bit  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= i_num;
                r_den  <= i_den;
                r_q    <= '0;
                r_bit  <= 3'(Q_W - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (w_fits) begin
                    r_rem <= r_rem - w_trial;
                end
                r_q <= {r_q[Q_W-2:0], w_fits};
                if (r_bit == 3'd0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_bit <= r_bit - 3'd1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_q    = r_q;

endmodule

// File: rtl/sent_rx_pulse_decoder.sv
// SENT receive front end: measures fall-to-fall intervals, locks onto the
// 56-tick sync pulse and decodes the 8 following nibbles into a frame.
module sent_rx_pulse_decoder
    import sent_pkg::*;
#(
    parameter int CLK_PER_TICK = 60,
    parameter int CNT_W        = 16,
    parameter int SYNC_MIN     = 42 * CLK_PER_TICK,
    parameter int SYNC_MAX     = 70 * CLK_PER_TICK
) (
    input  logic                      clk_rx,
    input  logic                      reset_n_rx,
    input  logic                      data_i,
    sent_rx_pulse_decoder_if.master   bus
);

    localparam logic [CNT_W-1:0] L_SYNC_MIN = CNT_W'(SYNC_MIN);
    localparam logic [CNT_W-1:0] L_SYNC_MAX = CNT_W'(SYNC_MAX);

    // Input conditioning and interval measurement.
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;

    // Control state.
    sent_state_t      r_state;
    sent_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_sync_q;
    logic [2:0]       r_idx;
    logic [3:0]       r_status_sh;
    logic [23:0]      r_data_sh;

    // Registered outputs.
    logic [3:0]       r_nibble;
    logic             r_nibble_valid;
    logic [2:0]       r_nibble_idx;
    logic             r_sync_pulse;
    logic [CNT_W-1:0] r_tick_cycles;
    logic [3:0]       r_status;
    logic [23:0]      r_data;
    logic [3:0]       r_crc;
    logic             r_frame_valid;
    logic             r_err;
    sent_err_t        r_err_code;

    // Decode strobes.
    logic             w_fall;
    logic             w_in_win;
    logic             w_sat;
    logic             w_lock;
    logic             w_start;
    logic             w_nib_ok;
    logic             w_last;
    logic             w_err;
    sent_err_t        w_err_code;

    // Divider interface.
    logic [NUM_W-1:0] w_num;
    logic [DEN_W-1:0] w_den;
    logic             w_div_busy;
    logic             w_div_done;
    logic [Q_W-1:0]   w_div_q;
    logic [3:0]       w_nibble;
    logic             w_q_ok;

    assign w_fall   = r_prev & ~r_sync2;
    assign w_in_win = (r_cnt >= L_SYNC_MIN) && (r_cnt <= L_SYNC_MAX);
    assign w_sat    = &r_cnt;
    assign w_last   = (r_idx == 3'(NIBBLES - 1));

    // Rounded tick count: (interval*112 + sync) / (2*sync).
    assign w_num    = NUM_W'(r_cnt) * NUM_W'(2 * SYNC_TICKS) + NUM_W'(r_sync_q);
    assign w_den    = DEN_W'({r_sync_q, 1'b0});
    assign w_q_ok   = q_in_range(w_div_q);
    assign w_nibble = nibble_of(w_div_q);

    sent_rx_divider u_div (
        .clk_rx     (clk_rx),
        .reset_n_rx (reset_n_rx),
        .i_start    (w_start),
        .i_num      (w_num),
        .i_den      (w_den),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_q        (w_div_q)
    );

    // Two-flop synchronizer, edge history and fall-to-fall interval counter.
    always_ff @(posedge clk_rx) begin
        if (!reset_n_rx) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= data_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_armed <= r_armed | w_fall;
            if (w_fall) begin
                r_cnt <= CNT_W'(1);
            end else if (!w_sat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_rx) begin
        if (!reset_n_rx) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and decode strobes; an error always pre-empts a nibble.
    always_comb begin
        w_state_nxt = r_state;
        w_lock      = 1'b0;
        w_start     = 1'b0;
        w_nib_ok    = 1'b0;
        w_err       = 1'b0;
        w_err_code  = ERR_NONE;
        case (r_state)
            HUNT: begin
                // The first fall after reset only opens the measurement.
                if (w_fall && r_armed && w_in_win) begin
                    w_lock      = 1'b1;
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (w_fall) begin
                    if (w_div_busy || w_div_done || (r_cnt >= r_sync_q)) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_RANGE;
                        w_state_nxt = HUNT;
                    end else begin
                        w_start = 1'b1;
                    end
                end else if (w_div_done) begin
                    if (w_q_ok) begin
                        w_nib_ok = 1'b1;
                        if (w_last) begin
                            w_state_nxt = CHECK_SYNC;
                        end
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_RANGE;
                        w_state_nxt = HUNT;
                    end
                end else if (w_sat) begin
                    w_err       = 1'b1;
                    w_err_code  = ERR_TIMEOUT;
                    w_state_nxt = HUNT;
                end
            end
            CHECK_SYNC: begin
                if (w_fall) begin
                    if (w_in_win) begin
                        w_lock      = 1'b1;
                        w_state_nxt = DECODE;
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_SYNC;
                        w_state_nxt = HUNT;
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    // Sync capture, nibble shadows and the registered output strobes.
    always_ff @(posedge clk_rx) begin
        if (!reset_n_rx) begin
            r_sync_q       <= '0;
            r_idx          <= '0;
            r_status_sh    <= '0;
            r_data_sh      <= '0;
            r_nibble       <= '0;
            r_nibble_valid <= 1'b0;
            r_nibble_idx   <= '0;
            r_sync_pulse   <= 1'b0;
            r_tick_cycles  <= '0;
            r_status       <= '0;
            r_data         <= '0;
            r_crc          <= '0;
            r_frame_valid  <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= ERR_NONE;
        end else begin
            r_nibble_valid <= 1'b0;
            r_sync_pulse   <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_err          <= 1'b0;
            if (w_lock) begin
                r_sync_q      <= r_cnt;
                r_tick_cycles <= r_cnt;
                r_sync_pulse  <= 1'b1;
                r_idx         <= '0;
            end
            if (w_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
            if (w_nib_ok) begin
                r_nibble       <= w_nibble;
                r_nibble_valid <= 1'b1;
                r_nibble_idx   <= r_idx;
                r_idx          <= r_idx + 3'd1;
                case (r_idx)
                    3'd0: r_status_sh       <= w_nibble;
                    3'd1: r_data_sh[23:20]  <= w_nibble;
                    3'd2: r_data_sh[19:16]  <= w_nibble;
                    3'd3: r_data_sh[15:12]  <= w_nibble;
                    3'd4: r_data_sh[11:8]   <= w_nibble;
                    3'd5: r_data_sh[7:4]    <= w_nibble;
                    3'd6: r_data_sh[3:0]    <= w_nibble;
                    default: begin
                        // CRC nibble completes the frame: publish everything.
                        r_status      <= r_status_sh;
                        r_data        <= r_data_sh;
                        r_crc         <= w_nibble;
                        r_frame_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.nibble_o       = r_nibble;
    assign bus.nibble_valid_o = r_nibble_valid;
    assign bus.nibble_idx_o   = r_nibble_idx;
    assign bus.sync_o         = r_sync_pulse;
    assign bus.tick_cycles_o  = r_tick_cycles;
    assign bus.status_o       = r_status;
    assign bus.data_o         = r_data;
    assign bus.crc_o          = r_crc;
    assign bus.frame_valid_o  = r_frame_valid;
    assign bus.err_o          = r_err;
    assign bus.err_code_o     = r_err_code;
    assign bus.state_o        = r_state;

endmodule

// File: tb/tb_sent_rx_pulse_decoder.sv
// Bench for the SENT receive pulse decoder, run at 20 clocks per tick with a
// 13-bit interval counter so that the saturation case stays short.
module tb_sent_rx_pulse_decoder;
  import sent_pkg::*;

  localparam int CPT  = 20;
  localparam int CW   = 13;
  localparam int MAXC = (1 << CW) - 1;
  localparam int SMIN = 42 * CPT;
  localparam int SMAX = 70 * CPT;
  localparam int LOW  = 40;

  // ---------------- clock / reset ----------------
  logic clk_rx = 1'b0;
  logic reset_n_rx = 1'b0;
  logic data_i = 1'b1;

  always #5 clk_rx = ~clk_rx;

  sent_rx_pulse_decoder_if #(.CNT_W(CW)) bus ();

  sent_rx_pulse_decoder #(
    .CLK_PER_TICK (CPT),
    .CNT_W        (CW)
  ) dut (
    .clk_rx     (clk_rx),
    .reset_n_rx (reset_n_rx),
    .data_i     (data_i),
    .bus        (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0] exp_sync_q[$];
  logic [6:0]    exp_nib_q[$];
  logic [31:0]   exp_frame_q[$];
  logic [1:0]    exp_err_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected strobe, nothing queued at %0t", name, $time);
  endtask

  // Monitor: pop and compare whenever the decoder presents a strobe.
  always @(negedge clk_rx) begin
    if (reset_n_rx) begin
      if (bus.sync_o) begin
        if (exp_sync_q.size() == 0) unexpected("sync");
        else chk("tick_cycles", 32'(bus.tick_cycles_o), 32'(exp_sync_q.pop_front()));
      end
      if (bus.nibble_valid_o) begin
        if (exp_nib_q.size() == 0) unexpected("nibble");
        else chk("nibble{idx,val}", 32'({bus.nibble_idx_o, bus.nibble_o}), 32'(exp_nib_q.pop_front()));
      end
      if (bus.frame_valid_o) begin
        if (exp_frame_q.size() == 0) unexpected("frame");
        else chk("frame{status,data,crc}", {bus.status_o, bus.data_o, bus.crc_o}, exp_frame_q.pop_front());
      end
      if (bus.err_o) begin
        if (exp_err_q.size() == 0) unexpected("err");
        else chk("err_code", 32'(bus.err_code_o), 32'(exp_err_q.pop_front()));
      end
    end
  end

  // ---------------- reference model ----------------
  // Protocol-level view: what a SENT receiver should report for each
  // fall-to-fall interval, using real-valued tick rounding.
  typedef enum int {M_HUNT, M_DATA, M_CHECK} m_mode_t;
  m_mode_t     m_mode  = M_HUNT;
  bit          m_armed = 1'b0;
  int          m_sync  = 0;
  int          m_idx   = 0;
  logic [31:0] m_word  = '0;

  task automatic model_reset();
    m_mode  = M_HUNT;
    m_armed = 1'b0;
    m_sync  = 0;
    m_idx   = 0;
    m_word  = '0;
    exp_sync_q.delete();
    exp_nib_q.delete();
    exp_frame_q.delete();
    exp_err_q.delete();
  endtask

  task automatic model_lock(input int g);
    m_sync = g;
    m_idx  = 0;
    m_mode = M_DATA;
    exp_sync_q.push_back(CW'(g));
  endtask

  task automatic model_fall(input int gap);
    int g;
    int q;
    g = (gap > MAXC) ? MAXC : gap;
    // A line that stays quiet past counter saturation during a frame times out.
    if (m_mode == M_DATA && gap > MAXC) begin
      exp_err_q.push_back(2'd3);
      m_mode = M_HUNT;
    end
    case (m_mode)
      M_HUNT: begin
        if (!m_armed) m_armed = 1'b1;
        else if (g >= SMIN && g <= SMAX) model_lock(g);
      end
      M_DATA: begin
        q = (g >= m_sync) ? 0 : $rtoi(real'(g) * 56.0 / real'(m_sync) + 0.5);
        if (q < 12 || q > 27) begin
          exp_err_q.push_back(2'd2);
          m_mode = M_HUNT;
        end else begin
          exp_nib_q.push_back({3'(m_idx), 4'(q - 12)});
          m_word[31 - 4*m_idx -: 4] = 4'(q - 12);
          m_idx++;
          if (m_idx == 8) begin
            exp_frame_q.push_back(m_word);
            m_mode = M_CHECK;
          end
        end
      end
      default: begin
        if (g >= SMIN && g <= SMAX) model_lock(g);
        else begin
          exp_err_q.push_back(2'd1);
          m_mode = M_HUNT;
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Next falling edge comes exactly gap cycles after the previous one.
  task automatic next_fall(input int gap);
    model_fall(gap);
    repeat (LOW) @(negedge clk_rx);
    data_i = 1'b1;
    repeat (gap - LOW) @(negedge clk_rx);
    data_i = 1'b0;
  endtask

  // Sync pulse then the first n nibbles of w, at t clocks per tick.
  task automatic send_frame(input real t, input logic [31:0] w, input int n);
    next_fall($rtoi(56.0 * t + 0.5));
    for (int k = 0; k < n; k++) begin
      logic [3:0] v;
      v = w[31 - 4*k -: 4];
      next_fall($rtoi((12.0 + real'(v)) * t + 0.5));
    end
  endtask

  task automatic check_reset_state();
    chk("rst nibble_o",       32'(bus.nibble_o), 32'd0);
    chk("rst nibble_valid_o", 32'(bus.nibble_valid_o), 32'd0);
    chk("rst nibble_idx_o",   32'(bus.nibble_idx_o), 32'd0);
    chk("rst sync_o",         32'(bus.sync_o), 32'd0);
    chk("rst tick_cycles_o",  32'(bus.tick_cycles_o), 32'd0);
    chk("rst status_o",       32'(bus.status_o), 32'd0);
    chk("rst data_o",         32'(bus.data_o), 32'd0);
    chk("rst crc_o",          32'(bus.crc_o), 32'd0);
    chk("rst frame_valid_o",  32'(bus.frame_valid_o), 32'd0);
    chk("rst err_o",          32'(bus.err_o), 32'd0);
    chk("rst err_code_o",     32'(bus.err_code_o), 32'd0);
    chk("rst state",          32'(bus.state_o), 32'(HUNT));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    real t;
    repeat (4) @(negedge clk_rx);
    check_reset_state();
    reset_n_rx = 1'b1;
    repeat (4) @(negedge clk_rx);

    // First fall only opens the measurement.
    next_fall(500);
    // Nominal frame: status 3, data 123456, CRC 9.
    send_frame(20.0, 32'h3123_4569, 8);
    // 2% slow ticks; nibble 5 lands near 17*20.4 cycles.
    send_frame(20.4, 32'h0_12345_A5, 8);
    // Non-sync interval after a complete frame: bad sync.
    next_fall(333);
    // 40 ticks is below the sync window: silently ignored in HUNT.
    next_fall(800);
    // Lock, two nibbles, then a 29-tick interval: out of range.
    send_frame(20.0, 32'h7AB0_0000, 2);
    next_fall(580);
    send_frame(20.0, 32'hC0FF_EE11, 8);

    // Randomized frames with up to +-2% tick deviation.
    for (int f = 0; f < 5; f++) begin
      t = real'(CPT) * (0.98 + real'($urandom_range(0, 40)) / 1000.0);
      send_frame(t, $urandom, 8);
    end

    // Sync then a line stuck high: timeout, then the late fall is ignored.
    send_frame(20.0, 32'h0, 0);
    next_fall(MAXC + 200);

    // Reset after nibble index 4, with the line high.
    send_frame(20.0, 32'h5ABC_DEF0, 5);
    repeat (LOW) @(negedge clk_rx);
    data_i = 1'b1;
    repeat (20) @(negedge clk_rx);
    reset_n_rx = 1'b0;
    @(negedge clk_rx);
    check_reset_state();
    reset_n_rx = 1'b1;
    model_reset();
    repeat (5) @(negedge clk_rx);
    next_fall(300);
    send_frame(20.0, 32'h9876_5432, 8);

    repeat (200) @(negedge clk_rx);
    chk("left sync",  32'(exp_sync_q.size()), 32'd0);
    chk("left nib",   32'(exp_nib_q.size()), 32'd0);
    chk("left frame", 32'(exp_frame_q.size()), 32'd0);
    chk("left err",   32'(exp_err_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
